// File: rtl/bitmem_rr_arbiter_if.sv
// Request/grant bundle between the CPU data-bit ports and the shared bit-memory arbiter.
// master = CPU side (drives REQ/LOCK), slave = arbiter side.
interface bitmem_rr_arbiter_if;
   logic [2:0] REQ;
   logic [2:0] LOCK;
   logic [2:0] GNT;
   logic [2:0] WT;
   logic [1:0] SEL;
   logic       BUSY;
   logic [1:0] LAST;
   logic       PREEMPT;

   modport master (output REQ, LOCK, input GNT, WT, SEL, BUSY, LAST, PREEMPT);
   modport slave  (input REQ, LOCK, output GNT, WT, SEL, BUSY, LAST, PREEMPT);
endinterface

// File: rtl/bitmem_rr_arbiter.sv
// Registered round-robin owner FSM for the shared semaphore bit memory (3 requesters).
// Optional hold-timeout preemption is compiled in when ARB_TIMEOUT_EN is defined.
module bitmem_rr_arbiter #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic               CLK,
   input  logic               CLR,
   bitmem_rr_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, OWN = 2'd1, GAP = 2'd2} state_t;

   state_t           state_reg, state_next;
   logic [2:0]       gnt_reg, gnt_next;
   logic [1:0]       sel_reg, sel_next;
   logic [1:0]       last_reg, last_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             preempt_reg, preempt_next;

   logic [1:0]       winner;
   logic             found;
   logic [2:0]       cand;
   logic             own_req, own_lock, other_req;

   if (MAX_HOLD < 2 || MAX_HOLD > (2**CNT_W - 1)) begin : g_bad_hold
      $error("bitmem_rr_arbiter: MAX_HOLD outside 2..2**CNT_W-1");
   end

   // Rotating scan starting just after the most recent owner, so it gets lowest priority.
   always_comb begin
      winner = 2'd0;
      found  = 1'b0;
      cand   = 3'd0;
      for (int i = 1; i <= 3; i++) begin
         cand = {1'b0, last_reg} + 3'(i);
         if (cand >= 3'd3)
            cand = cand - 3'd3;
         if (!found && bus.REQ[cand[1:0]]) begin
            winner = cand[1:0];
            found  = 1'b1;
         end
      end
   end

   assign own_req   = |(bus.REQ & gnt_reg);
   assign own_lock  = |(bus.LOCK & gnt_reg);
   assign other_req = |(bus.REQ & ~gnt_reg);

   always_comb begin
      state_next   = state_reg;
      gnt_next     = gnt_reg;
      sel_next     = sel_reg;
      last_next    = last_reg;
      cnt_next     = cnt_reg;
      preempt_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (found) begin
               state_next = OWN;
               gnt_next   = 3'b001 << winner;
               sel_next   = winner;
               last_next  = winner;
               cnt_next   = CNT_W'(1);
            end
         end
         OWN: begin
            if (own_req || own_lock) begin
`ifdef ARB_TIMEOUT_EN
               if (cnt_reg >= CNT_W'(MAX_HOLD) && !own_lock && other_req) begin
                  state_next   = GAP;
                  gnt_next     = 3'b000;
                  sel_next     = 2'd3;
                  cnt_next     = '0;
                  preempt_next = 1'b1;
               end else if (cnt_reg != '1) begin
                  cnt_next = cnt_reg + 1'b1;
               end
`else
               if (cnt_reg != '1)
                  cnt_next = cnt_reg + 1'b1;
`endif
            end else begin
               state_next = GAP;
               gnt_next   = 3'b000;
               sel_next   = 2'd3;
               cnt_next   = '0;
            end
         end
         // Bus turnaround: one dead cycle before arbitration resumes.
         GAP: begin
            state_next = IDLE;
            gnt_next   = 3'b000;
            sel_next   = 2'd3;
            cnt_next   = '0;
         end
         default: begin
            state_next = IDLE;
            gnt_next   = 3'b000;
            sel_next   = 2'd3;
            cnt_next   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!CLR) begin
         state_reg   <= IDLE;
         gnt_reg     <= 3'b000;
         sel_reg     <= 2'd3;
         last_reg    <= 2'd2;
         cnt_reg     <= '0;
         preempt_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         gnt_reg     <= gnt_next;
         sel_reg     <= sel_next;
         last_reg    <= last_next;
         cnt_reg     <= cnt_next;
         preempt_reg <= preempt_next;
      end
   end

   // WT is the only output with a combinational path from the requests.
   assign bus.WT      = bus.REQ & ~gnt_reg;
   assign bus.GNT     = gnt_reg;
   assign bus.SEL     = sel_reg;
   assign bus.BUSY    = |gnt_reg;
   assign bus.LAST    = last_reg;
   assign bus.PREEMPT = preempt_reg;
endmodule

// File: tb/tb_bitmem_rr_arbiter.sv
// Bench for bitmem_rr_arbiter: directed scenarios with hand-computed GNT/LAST,
// then randomized traffic, all checked each cycle against an owner/queue-level model.
module tb_bitmem_rr_arbiter;
   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 5;
   localparam int SAT      = 31;
`ifdef ARB_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif

   logic CLK = 1'b0;
   logic CLR = 1'b0;
   always #5 CLK = ~CLK;

   bitmem_rr_arbiter_if bus_if ();

   bitmem_rr_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus_if)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0d required %0d at t=%0t", name, act, exp, $time);
   endtask

   // Model: who owns the bus (-1 none), whether the turnaround cycle is pending,
   // the rotation pointer and how long the owner has held the grant.
   int m_owner = -1;
   bit m_gap   = 1'b0;
   int m_last  = 2;
   int m_held  = 0;
   bit m_pre   = 1'b0;

   task automatic model_step();
      logic [2:0] r, l;
      r = bus_if.REQ;
      l = bus_if.LOCK;
      if (!CLR) begin
         m_owner = -1; m_gap = 1'b0; m_last = 2; m_held = 0; m_pre = 1'b0;
         return;
      end
      m_pre = 1'b0;
      if (m_gap) begin
         m_gap = 1'b0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= 3; k++) begin
            int c;
            c = (m_last + k) % 3;
            if (r[c]) begin
               m_owner = c;
               m_last  = c;
               m_held  = 1;
               break;
            end
         end
      end else if (r[m_owner] || l[m_owner]) begin
         if (TMO && m_held >= MAX_HOLD && !l[m_owner] && ((r & ~(3'b001 << m_owner)) != 3'b000)) begin
            m_owner = -1; m_gap = 1'b1; m_pre = 1'b1;
         end else if (m_held < SAT) begin
            m_held++;
         end
      end else begin
         m_owner = -1;
         m_gap   = 1'b1;
      end
   endtask

   // Compare process: model advances on each rising edge, outputs sampled 1 time unit later.
   initial begin
      logic [2:0] eg;
      forever begin
         @(posedge CLK);
         model_step();
         #1;
         eg = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
         check("GNT", 32'(bus_if.GNT), 32'(eg));
         check("SEL", 32'(bus_if.SEL), (m_owner >= 0) ? 32'(m_owner) : 32'd3);
         check("BUSY", 32'(bus_if.BUSY), 32'(m_owner >= 0));
         check("LAST", 32'(bus_if.LAST), 32'(m_last));
         check("PREEMPT", 32'(bus_if.PREEMPT), 32'(m_pre));
         check("WT", 32'(bus_if.WT), 32'(bus_if.REQ & ~eg));
      end
   end

   // Drive n cycles of fixed inputs; after each edge compare GNT/LAST with hand-derived values.
   // tmo marks rows whose literal values only hold when preemption is compiled out.
   task automatic step(input int n, input logic clr, input logic [2:0] req, input logic [2:0] lock,
                       input logic [2:0] gnt, input logic [1:0] last, input bit tmo);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         CLR         = clr;
         bus_if.REQ  = req;
         bus_if.LOCK = lock;
         @(posedge CLK);
         #2;
         if (!(TMO && tmo)) begin
            check($sformatf("lit_GNT req=%b lock=%b", req, lock), 32'(bus_if.GNT), 32'(gnt));
            check($sformatf("lit_LAST req=%b lock=%b", req, lock), 32'(bus_if.LAST), 32'(last));
         end
      end
   endtask

   initial begin
      CLR         = 1'b0;
      bus_if.REQ  = 3'b000;
      bus_if.LOCK = 3'b000;
      // reset with all requests pending, then first grant
      step(2, 1'b0, 3'b111, 3'b000, 3'b000, 2'd2, 1'b0);
      step(2, 1'b1, 3'b111, 3'b000, 3'b001, 2'd0, 1'b0);
      // rotation with a fixed two-cycle gap between owners
      step(1, 1'b1, 3'b110, 3'b000, 3'b000, 2'd0, 1'b0);
      step(1, 1'b1, 3'b111, 3'b000, 3'b000, 2'd0, 1'b0);
      step(2, 1'b1, 3'b111, 3'b000, 3'b010, 2'd1, 1'b0);
      step(1, 1'b1, 3'b101, 3'b000, 3'b000, 2'd1, 1'b0);
      step(1, 1'b1, 3'b111, 3'b000, 3'b000, 2'd1, 1'b0);
      step(2, 1'b1, 3'b111, 3'b000, 3'b100, 2'd2, 1'b0);
      step(1, 1'b1, 3'b011, 3'b000, 3'b000, 2'd2, 1'b0);
      step(1, 1'b1, 3'b111, 3'b000, 3'b000, 2'd2, 1'b0);
      step(1, 1'b1, 3'b111, 3'b000, 3'b001, 2'd0, 1'b0);
      // single requester held for six cycles
      step(2, 1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
      step(6, 1'b1, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
      step(2, 1'b1, 3'b000, 3'b000, 3'b000, 2'd1, 1'b0);
      // owner 0 keeps the bus via LOCK while requester 1 waits
      step(1, 1'b1, 3'b011, 3'b000, 3'b001, 2'd0, 1'b0);
      step(5, 1'b1, 3'b010, 3'b001, 3'b001, 2'd0, 1'b0);
      step(2, 1'b1, 3'b010, 3'b000, 3'b000, 2'd0, 1'b0);
      step(1, 1'b1, 3'b010, 3'b000, 3'b010, 2'd1, 1'b0);
      // reset in the middle of a grant to requester 2
      step(2, 1'b1, 3'b101, 3'b000, 3'b000, 2'd1, 1'b0);
      step(1, 1'b1, 3'b101, 3'b000, 3'b100, 2'd2, 1'b0);
      step(1, 1'b0, 3'b111, 3'b000, 3'b000, 2'd2, 1'b0);
      step(1, 1'b1, 3'b111, 3'b000, 3'b001, 2'd0, 1'b0);
      // long hold with a competing requester: preempted only when timeout is built in
      step(8, 1'b1, 3'b101, 3'b000, 3'b001, 2'd0, 1'b1);
      step(3, 1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b1);
      step(2, 1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
      // same contention but LOCK[0] held: never preempted
      step(1, 1'b1, 3'b001, 3'b001, 3'b001, 2'd0, 1'b0);
      step(8, 1'b1, 3'b101, 3'b001, 3'b001, 2'd0, 1'b0);
      // LOCK alone in IDLE grants nothing
      step(1, 1'b1, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0);
      step(3, 1'b1, 3'b000, 3'b111, 3'b000, 2'd0, 1'b0);

      // randomized traffic with sticky requests, sparse locks and rare resets
      for (int c = 0; c < 2000; c++) begin
         @(negedge CLK);
         CLR = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 2) == 0)
            bus_if.REQ = 3'($urandom_range(0, 7));
         for (int b = 0; b < 3; b++)
            bus_if.LOCK[b] = ($urandom_range(0, 7) == 0);
      end

      @(negedge CLK);
      @(negedge CLK);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
